gameover_sequencer: RTL and testbench
=====================================

Name: gameover_sequencer

Overview:
- Frame-timed controller that sequences the game-over skull/eyes overlay drawn by the game-over renderer.
- Sits between the game FSM (gameover level) and the VGA pixel mux. Gates the skull and eyes layers per frame.
- Flashes the skull on entry, then holds the screen. Arms restart only after a minimum display time and a fresh start-button press.

Parameters:
- FLASH_COUNT, 4, number of skull on/off flash cycles on entry (1..15)
- FLASH_FRAMES, 15, frames per flash half-period (1..255)
- BLINK_FRAMES, 30, frames per eye blink half-period in SHOW (1..255)
- HOLD_FRAMES, 120, minimum frames in SHOW before restart is accepted (1..255)

Ports:
- clk  input  1  system clock (pixel clock domain)
- rst  input  1  asynchronous, active-high reset
- frame_tick  input  1  one-cycle pulse per video frame (end of active area)
- gameover  input  1  level from game FSM; high while the game is lost
- start_btn  input  1  debounced, synchronized start button level
- skull_en  output  1  enable skull layer in pixel mux
- eyes_en  output  1  enable eyes layer in pixel mux
- overlay_active  output  1  high in any state except IDLE; game mux blanks playfield
- restart  output  1  single-cycle pulse requesting new game
- seq_state  output  2  current state encoding, for debug/LEDs

Behaviour:
- Reset, async: state IDLE, all counters 0. skull_en=0, eyes_en=0, overlay_active=0, restart=0, btn_prev=1 so a button held at reset is not an edge.
- States: IDLE=0, FLASH=1, SHOW=2, ARMED=3. All outputs are registered.
- IDLE: outputs 0. On the cycle gameover is high, go to FLASH next cycle, with frame_cnt=0, flash_cnt=0, skull phase on.
- FLASH: skull_en=phase, eyes_en=0. frame_cnt increments only on frame_tick.
  - When frame_cnt reaches FLASH_FRAMES-1 on a tick: frame_cnt←0 and phase toggles. flash_cnt increments on each off→on toggle.
  - When flash_cnt=FLASH_COUNT and phase returns on: go to SHOW with frame_cnt=0.
  - Total FLASH duration = 2*FLASH_COUNT*FLASH_FRAMES ticks.
- SHOW: skull_en=1, eyes_en per blink rule (see Optional Feature). hold_cnt increments on each frame_tick and saturates. At hold_cnt=HOLD_FRAMES-1 on a tick, go to ARMED.
- ARMED: skull_en=1, eyes blink continues. A rising edge of start_btn (start_btn=1, btn_prev=0) sets restart=1 for exactly one cycle, then the state goes to IDLE the same cycle.
- btn_prev samples start_btn every cycle, in all states. Presses during FLASH/SHOW are ignored; a button still held on entry to ARMED must be released and pressed again.
- gameover deasserted in FLASH/SHOW/ARMED: abort to IDLE next cycle with no restart pulse. This has priority over every other transition.
- restart is only generated from ARMED. After restart, IDLE re-enters FLASH if gameover is still high. The game FSM must drop gameover within 1 cycle of restart.
- frame_tick coincident with a state transition: the tick is consumed by the transition. Counters in the new state start from 0.
- Counters are 8-bit unsigned. Compare is equality; there is no wrap because counters reset on reaching terminal value.
- Latency: gameover↑ → overlay_active=1 after 1 clk. Button edge → restart after 1 clk.

Optional Feature:
- Macro GAMEOVER_EYE_BLINK_EN.
- Defined: in SHOW/ARMED, eyes_en toggles every BLINK_FRAMES ticks, starting at 1 on SHOW entry. The blink counter is independent of hold_cnt.
- Undefined: eyes_en=1 constantly in SHOW/ARMED, and no blink counter is synthesized. FLASH/IDLE behaviour is unchanged in both builds.

Test Plan:
- Reset with gameover=0, then 100 ticks → all outputs 0, seq_state=0. Assert rst mid-FLASH → outputs 0 immediately (async), without waiting for clk.
- gameover↑ with default params, frame_tick every 10 clk → skull_en toggles every 15 ticks. Exactly 4 on-pulses, then seq_state=2 after 120 ticks; eyes_en=0 throughout FLASH.
- In SHOW press start_btn at tick 50 → no restart. After tick 120, seq_state=3. Release, then press → restart high for exactly 1 clk and seq_state=0.
- start_btn held continuously from FLASH through entry to ARMED → no restart until release then re-press.
- gameover dropped at tick 60 of SHOW → seq_state=0 next clk, restart never asserted, overlay_active=0.
- With GAMEOVER_EYE_BLINK_EN defined, BLINK_FRAMES=30 → eyes_en 1 for 30 ticks, 0 for 30, repeating. Undefined → eyes_en stays 1 for 300 ticks of SHOW/ARMED.

Source files
------------

// File: rtl/gameover_sequencer.sv
// Game-over overlay sequencer: flashes the skull, holds the screen, then arms restart.
// Optional eye blinking in SHOW/ARMED is enabled by defining GAMEOVER_EYE_BLINK_EN.
module gameover_sequencer #(
    parameter int FLASH_COUNT  = 4,
    parameter int FLASH_FRAMES = 15,
    parameter int BLINK_FRAMES = 30,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       gameover,
    input  logic       start_btn,
    output logic       skull_en,
    output logic       eyes_en,
    output logic       overlay_active,
    output logic       restart,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        SHOW  = 2'd2,
        ARMED = 2'd3
    } state_t;

    localparam logic [7:0] FLASH_LAST  = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] FLASH_TOTAL = 8'(FLASH_COUNT);
`ifdef GAMEOVER_EYE_BLINK_EN
    localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
`endif

    state_t     r_state;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_flash_cnt;
    logic [7:0] r_hold_cnt;
    logic       r_phase;
    logic       r_btn_prev;
    logic       r_skull_en;
    logic       r_eyes_en;
    logic       r_overlay;
    logic       r_restart;
`ifdef GAMEOVER_EYE_BLINK_EN
    logic [7:0] r_blink_cnt;
`endif

    logic       w_btn_rise;
    logic [7:0] w_flash_next;

    assign w_btn_rise   = start_btn & ~r_btn_prev;
    assign w_flash_next = r_flash_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_frame_cnt <= 8'd0;
            r_flash_cnt <= 8'd0;
            r_hold_cnt  <= 8'd0;
            r_phase     <= 1'b0;
            r_btn_prev  <= 1'b1;
            r_skull_en  <= 1'b0;
            r_eyes_en   <= 1'b0;
            r_overlay   <= 1'b0;
            r_restart   <= 1'b0;
`ifdef GAMEOVER_EYE_BLINK_EN
            r_blink_cnt <= 8'd0;
`endif
        end else begin
            r_btn_prev <= start_btn;
            r_restart  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_skull_en <= 1'b0;
                    r_eyes_en  <= 1'b0;
                    r_overlay  <= 1'b0;
                    if (gameover) begin
                        r_state     <= FLASH;
                        r_frame_cnt <= 8'd0;
                        r_flash_cnt <= 8'd0;
                        r_phase     <= 1'b1;
                        r_skull_en  <= 1'b1;
                        r_overlay   <= 1'b1;
                    end
                end
                FLASH: begin
                    if (!gameover) begin
                        r_state     <= IDLE;
                        r_frame_cnt <= 8'd0;
                        r_flash_cnt <= 8'd0;
                        r_phase     <= 1'b0;
                        r_skull_en  <= 1'b0;
                        r_eyes_en   <= 1'b0;
                        r_overlay   <= 1'b0;
                    end else if (frame_tick) begin
                        if (r_frame_cnt == FLASH_LAST) begin
                            r_frame_cnt <= 8'd0;
                            r_phase     <= ~r_phase;
                            r_skull_en  <= ~r_phase;
                            // Off->on edge closes one flash cycle; the last one hands over to SHOW.
                            if (!r_phase) begin
                                r_flash_cnt <= w_flash_next;
                                if (w_flash_next == FLASH_TOTAL) begin
                                    r_state    <= SHOW;
                                    r_hold_cnt <= 8'd0;
                                    r_eyes_en  <= 1'b1;
`ifdef GAMEOVER_EYE_BLINK_EN
                                    r_blink_cnt <= 8'd0;
`endif
                                end
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                SHOW: begin
                    if (!gameover) begin
                        r_state    <= IDLE;
                        r_hold_cnt <= 8'd0;
                        r_phase    <= 1'b0;
                        r_skull_en <= 1'b0;
                        r_eyes_en  <= 1'b0;
                        r_overlay  <= 1'b0;
                    end else if (frame_tick) begin
`ifdef GAMEOVER_EYE_BLINK_EN
                        if (r_blink_cnt == BLINK_LAST) begin
                            r_blink_cnt <= 8'd0;
                            r_eyes_en   <= ~r_eyes_en;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 8'd1;
                        end
`endif
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state <= ARMED;
                        end else if (r_hold_cnt != 8'hFF) begin
                            r_hold_cnt <= r_hold_cnt + 8'd1;
                        end
                    end
                end
                ARMED: begin
                    if (!gameover || w_btn_rise) begin
                        r_state    <= IDLE;
                        r_restart  <= gameover;
                        r_hold_cnt <= 8'd0;
                        r_phase    <= 1'b0;
                        r_skull_en <= 1'b0;
                        r_eyes_en  <= 1'b0;
                        r_overlay  <= 1'b0;
                    end else if (frame_tick) begin
`ifdef GAMEOVER_EYE_BLINK_EN
                        if (r_blink_cnt == BLINK_LAST) begin
                            r_blink_cnt <= 8'd0;
                            r_eyes_en   <= ~r_eyes_en;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign skull_en       = r_skull_en;
    assign eyes_en        = r_eyes_en;
    assign overlay_active = r_overlay;
    assign restart        = r_restart;
    assign seq_state      = r_state;

endmodule

// File: tb/tb_gameover_sequencer.sv
// Directed self-checking bench for gameover_sequencer with default parameters.
module tb_gameover_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       gameover = 1'b0;
    logic       start_btn = 1'b0;
    logic       skull_en;
    logic       eyes_en;
    logic       overlay_active;
    logic       restart;
    logic [1:0] seq_state;

    int checks = 0;
    int failures = 0;
    int n_restart = 0;

    gameover_sequencer dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .gameover(gameover),
        .start_btn(start_btn),
        .skull_en(skull_en),
        .eyes_en(eyes_en),
        .overlay_active(overlay_active),
        .restart(restart),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (restart === 1'b1) n_restart++;

    // One frame: a single-cycle tick followed by idle cycles (10 clocks total).
    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    function automatic logic exp_eyes(input int k);
`ifdef GAMEOVER_EYE_BLINK_EN
        return ((k / 30) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; gameover = 1'b0; start_btn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({skull_en, eyes_en, overlay_active, restart, seq_state} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state: got %b want 000000", {skull_en, eyes_en, overlay_active, restart, seq_state});
        end
        rst = 1'b0;
        for (int t = 0; t < 100; t++) begin
            do_tick();
            if ({skull_en, eyes_en, overlay_active, restart, seq_state} !== 6'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_100_ticks: %0d ticks with nonzero outputs, want 0", bad);
        end
    endtask

    task automatic test_flash();
        int pulses = 1;
        int bad_skull = 0, bad_eyes = 0, bad_state = 0;
        logic prev_skull = 1'b1;
        @(negedge clk) gameover = 1'b1;
        @(negedge clk);
        checks++;
        if (overlay_active !== 1'b1 || seq_state !== 2'd1 || skull_en !== 1'b1 || eyes_en !== 1'b0) begin
            failures++;
            $display("FAIL flash_entry: ov=%b st=%0d sk=%b ey=%b want 1 1 1 0", overlay_active, seq_state, skull_en, eyes_en);
        end
        for (int t = 1; t < 120; t++) begin
            do_tick();
            if (skull_en !== (((t / 15) % 2) == 0)) bad_skull++;
            if (eyes_en !== 1'b0) bad_eyes++;
            if (seq_state !== 2'd1) bad_state++;
            if (skull_en === 1'b1 && prev_skull === 1'b0) pulses++;
            prev_skull = skull_en;
        end
        checks++;
        if (bad_skull != 0) begin failures++; $display("FAIL flash_skull_pattern: %0d bad ticks, want 0", bad_skull); end
        checks++;
        if (bad_eyes != 0) begin failures++; $display("FAIL flash_eyes_off: %0d bad ticks, want 0", bad_eyes); end
        checks++;
        if (bad_state != 0) begin failures++; $display("FAIL flash_state: %0d bad ticks, want 0", bad_state); end
        checks++;
        if (pulses != 4) begin failures++; $display("FAIL flash_pulses: got %0d want 4", pulses); end
        do_tick();
        checks++;
        if (seq_state !== 2'd2 || skull_en !== 1'b1 || eyes_en !== 1'b1) begin
            failures++;
            $display("FAIL show_entry: st=%0d sk=%b ey=%b want 2 1 1", seq_state, skull_en, eyes_en);
        end
    endtask

    task automatic test_show_press();
        int r0 = n_restart;
        int bad_eyes = 0, bad_state = 0;
        for (int k = 1; k <= 300; k++) begin
            if (k == 50) start_btn = 1'b1;
            if (k == 55) start_btn = 1'b0;
            do_tick();
            if (eyes_en !== exp_eyes(k) || skull_en !== 1'b1) bad_eyes++;
            if (seq_state !== ((k < 120) ? 2'd2 : 2'd3)) bad_state++;
        end
        checks++;
        if (n_restart != r0) begin failures++; $display("FAIL show_press_ignored: %0d restarts, want 0", n_restart - r0); end
        checks++;
        if (bad_eyes != 0) begin failures++; $display("FAIL show_armed_eyes: %0d bad ticks, want 0", bad_eyes); end
        checks++;
        if (bad_state != 0) begin failures++; $display("FAIL show_to_armed: %0d bad ticks, want 0", bad_state); end
        @(negedge clk) start_btn = 1'b1;
        @(negedge clk);
        checks++;
        if (restart !== 1'b1 || seq_state !== 2'd0 || overlay_active !== 1'b0) begin
            failures++;
            $display("FAIL armed_restart: rs=%b st=%0d ov=%b want 1 0 0", restart, seq_state, overlay_active);
        end
        gameover = 1'b0;
        @(negedge clk);
        checks++;
        if (restart !== 1'b0 || seq_state !== 2'd0) begin
            failures++;
            $display("FAIL restart_single: rs=%b st=%0d want 0 0", restart, seq_state);
        end
        start_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_held_button();
        int r0;
        start_btn = 1'b1;
        repeat (2) @(negedge clk);
        r0 = n_restart;
        gameover = 1'b1;
        for (int t = 0; t < 245; t++) do_tick();
        checks++;
        if (seq_state !== 2'd3 || n_restart != r0) begin
            failures++;
            $display("FAIL held_no_restart: st=%0d restarts=%0d want 3 0", seq_state, n_restart - r0);
        end
        @(negedge clk) start_btn = 1'b0;
        @(negedge clk);
        checks++;
        if (seq_state !== 2'd3 || restart !== 1'b0) begin
            failures++;
            $display("FAIL held_release: st=%0d rs=%b want 3 0", seq_state, restart);
        end
        start_btn = 1'b1;
        @(negedge clk);
        checks++;
        if (restart !== 1'b1 || seq_state !== 2'd0) begin
            failures++;
            $display("FAIL held_repress: rs=%b st=%0d want 1 0", restart, seq_state);
        end
        gameover = 1'b0;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        checks++;
        if (n_restart != r0 + 1) begin
            failures++;
            $display("FAIL held_pulse_count: got %0d want 1", n_restart - r0);
        end
    endtask

    task automatic test_abort();
        int r0 = n_restart;
        @(negedge clk) gameover = 1'b1;
        for (int t = 0; t < 180; t++) do_tick();
        checks++;
        if (seq_state !== 2'd2) begin failures++; $display("FAIL abort_pre_state: got %0d want 2", seq_state); end
        gameover = 1'b0;
        @(negedge clk);
        checks++;
        if (seq_state !== 2'd0 || overlay_active !== 1'b0 || skull_en !== 1'b0 || eyes_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: st=%0d ov=%b sk=%b ey=%b want 0 0 0 0", seq_state, overlay_active, skull_en, eyes_en);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (n_restart != r0) begin failures++; $display("FAIL abort_no_restart: got %0d want 0", n_restart - r0); end
    endtask

    task automatic test_async_reset();
        @(negedge clk) gameover = 1'b1;
        for (int t = 0; t < 20; t++) do_tick();
        checks++;
        if (seq_state !== 2'd1 || skull_en !== 1'b0) begin
            failures++;
            $display("FAIL midflash_pre: st=%0d sk=%b want 1 0", seq_state, skull_en);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({skull_en, eyes_en, overlay_active, restart, seq_state} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset: got %b want 000000", {skull_en, eyes_en, overlay_active, restart, seq_state});
        end
        gameover = 1'b0;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (seq_state !== 2'd0 || overlay_active !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: st=%0d ov=%b want 0 0", seq_state, overlay_active);
        end
    endtask

    initial begin
        test_reset();
        test_flash();
        test_show_press();
        test_held_button();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
